// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline front end.
package mips_pipe_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    PC_INC        = PC_W'(4);
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = INSTR_W'(0);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        REDIRECT = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus4;
        logic               valid;
    } if_id_t;

    // Sequential next PC; wraps naturally at 32 bits.
    function automatic logic [PC_W-1:0] pc_seq(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write-enable load, flush squashes to a NOP bubble.
module if_id_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic               flush,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc_plus4,
    input  logic               d_valid,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc_plus4,
    output logic               q_valid
);

    if_id_t q;

    // Flush beats any load; a flushed slot keeps its pc_plus4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
        end else if (flush) begin
            q.instr    <= NOP_INSTR;
            q.valid    <= 1'b0;
        end else if (we) begin
            q.instr    <= d_instr;
            q.pc_plus4 <= d_pc_plus4;
            q.valid    <= d_valid;
        end
    end

    assign q_instr    = q.instr;
    assign q_pc_plus4 = q.pc_plus4;
    assign q_valid    = q.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, next-PC select, imem handshake FSM, one-entry fetch
// buffer and the IF/ID register feeding decode.
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCWrite_in,
    input  logic               IF_ID_write_in,
    input  logic               flush_in,
    input  logic               branch_taken_in,
    input  logic [PC_W-1:0]    branch_target_in,
    input  logic               jump_in,
    input  logic [PC_W-1:0]    jump_target_in,
    output logic               imem_req_out,
    output logic [PC_W-1:0]    imem_addr_out,
    input  logic               imem_ready_in,
    input  logic [INSTR_W-1:0] imem_rdata_in,
    output logic [INSTR_W-1:0] IF_ID_instr_out,
    output logic [PC_W-1:0]    IF_ID_pc_plus4_out,
    output logic               IF_ID_valid_out,
    output logic               fetch_stall_out
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pend_q, pend_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               started_q;

    logic               redirect;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    pc_plus4;
    logic               deliver;
    logic [INSTR_W-1:0] deliver_instr;
    logic [INSTR_W-1:0] ifid_d_instr;
    logic [PC_W-1:0]    ifid_d_pc_plus4;

    assign redirect = PCWrite_in & (jump_in | branch_taken_in);
    assign target   = jump_in ? jump_target_in : branch_target_in;
    assign pc_plus4 = pc_seq(pc_q);

    // Holds off the first request until one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        buf_d         = buf_q;
        deliver       = 1'b0;
        deliver_instr = buf_q;
        if (started_q) begin
            case (state_q)
                FETCH: begin
                    if (imem_ready_in) begin
                        if (redirect) begin
                            pc_d = target;
                        end else if (PCWrite_in && IF_ID_write_in) begin
                            deliver       = 1'b1;
                            deliver_instr = imem_rdata_in;
                            pc_d          = pc_plus4;
                        end else begin
                            buf_d   = imem_rdata_in;
                            state_d = HOLD;
                        end
                    end else if (redirect) begin
                        pend_d  = target;
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: begin
                    // The newest redirect wins, even on the ready cycle.
                    if (redirect) begin
                        pend_d = target;
                    end
                    if (imem_ready_in) begin
                        pc_d    = redirect ? target : pend_q;
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end else if (PCWrite_in && IF_ID_write_in) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Any IF/ID write without a delivered instruction becomes a bubble.
    assign ifid_d_instr    = deliver ? deliver_instr : NOP_INSTR;
    assign ifid_d_pc_plus4 = deliver ? pc_plus4 : IF_ID_pc_plus4_out;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (IF_ID_write_in),
        .flush      (flush_in),
        .d_instr    (ifid_d_instr),
        .d_pc_plus4 (ifid_d_pc_plus4),
        .d_valid    (deliver),
        .q_instr    (IF_ID_instr_out),
        .q_pc_plus4 (IF_ID_pc_plus4_out),
        .q_valid    (IF_ID_valid_out)
    );

    assign imem_req_out    = started_q && (state_q != HOLD);
    assign imem_addr_out   = pc_q;
    assign fetch_stall_out = imem_req_out && !imem_ready_in;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a random run
// against a cycle-level behavioural model of the fetch rules.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pcw, ifw, fl, br, jp, rdy;
    logic [31:0] bt, jt, rd;
    logic        req, valid, stall;
    logic [31:0] addr, instr, p4;

    logic        w_rst_n, w_req, w_valid, w_stall;
    logic [31:0] w_addr, w_instr, w_p4;
    localparam logic [31:0] W_RDATA = 32'h1234_5678;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PCWrite_in(pcw), .IF_ID_write_in(ifw), .flush_in(fl),
        .branch_taken_in(br), .branch_target_in(bt), .jump_in(jp), .jump_target_in(jt),
        .imem_req_out(req), .imem_addr_out(addr), .imem_ready_in(rdy), .imem_rdata_in(rd),
        .IF_ID_instr_out(instr), .IF_ID_pc_plus4_out(p4), .IF_ID_valid_out(valid),
        .fetch_stall_out(stall)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .PCWrite_in(1'b1), .IF_ID_write_in(1'b1), .flush_in(1'b0),
        .branch_taken_in(1'b0), .branch_target_in(32'h0), .jump_in(1'b0), .jump_target_in(32'h0),
        .imem_req_out(w_req), .imem_addr_out(w_addr), .imem_ready_in(1'b1), .imem_rdata_in(W_RDATA),
        .IF_ID_instr_out(w_instr), .IF_ID_pc_plus4_out(w_p4), .IF_ID_valid_out(w_valid),
        .fetch_stall_out(w_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural view of PC, held instruction, pending target, IF/ID.
    logic [31:0] m_pc, m_buf, m_ptgt, m_instr, m_p4;
    bit          m_started, m_hold, m_pend, m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_buf = NOP; m_ptgt = 32'h0;
        m_instr = NOP; m_p4 = 32'h0; m_valid = 1'b0;
        m_started = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit          redir, dlv;
        logic [31:0] tgt, dl_i, dl_p4;
        redir = pcw && (jp || br);
        tgt   = jp ? jt : bt;
        dlv = 1'b0; dl_i = NOP; dl_p4 = 32'h0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_hold) begin
            if (redir) begin
                m_pc = tgt; m_hold = 1'b0;
            end else if (pcw && ifw) begin
                dlv = 1'b1; dl_i = m_buf; dl_p4 = m_pc + 32'd4;
                m_pc = m_pc + 32'd4; m_hold = 1'b0;
            end
        end else if (m_pend) begin
            if (rdy) begin
                m_pc = redir ? tgt : m_ptgt; m_pend = 1'b0;
            end else if (redir) begin
                m_ptgt = tgt;
            end
        end else if (rdy) begin
            if (redir) begin
                m_pc = tgt;
            end else if (pcw && ifw) begin
                dlv = 1'b1; dl_i = rd; dl_p4 = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
            end else begin
                m_buf = rd; m_hold = 1'b1;
            end
        end else if (redir) begin
            m_pend = 1'b1; m_ptgt = tgt;
        end
        if (fl) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (dlv) begin
            m_instr = dl_i; m_p4 = dl_p4; m_valid = 1'b1;
        end else if (ifw) begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endtask

    task automatic drive(input bit a_pcw, input bit a_ifw, input bit a_fl,
                         input bit a_br, input logic [31:0] a_bt,
                         input bit a_jp, input logic [31:0] a_jt,
                         input bit a_rdy, input logic [31:0] a_rd);
        pcw = a_pcw; ifw = a_ifw; fl = a_fl; br = a_br; bt = a_bt;
        jp = a_jp; jt = a_jt; rdy = a_rdy; rd = a_rd;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 1'($urandom), $urandom);
            advance();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_tests++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
        n_tests++; if (p4 !== 32'h0 || instr !== NOP) begin n_fail++; $display("FAIL reset_ifid: got %h/%h expected 0/0", instr, p4); end
        advance(); advance();
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req_held: got %b expected 0", req); end
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hA000_0000);
        advance();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (req !== 1'b1 || addr !== 32'(i * 4)) begin
                n_fail++; $display("FAIL reset_seq%0d: got req=%b addr=%h expected req=1 addr=%h", i, req, addr, 32'(i * 4));
            end
            if (i < 2) begin
                drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
                advance();
            end
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hB000_0008);
        advance();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (req !== 1'b0 || addr !== 32'h8) begin
                n_fail++; $display("FAIL stall_hold%0d: got req=%b addr=%h expected req=0 addr=8", i, req, addr);
            end
            n_tests++;
            if (instr !== 32'hA000_0001 || p4 !== 32'h8 || valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_frozen%0d: got %h/%h/%b expected a0000001/8/1", i, instr, p4, valid);
            end
            drive(0, 0, 0, 0, 0, 0, 0, 1'(i), 32'hDEAD_0000);
            if (i == 0) advance();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD_0001);
        advance();
        n_tests++;
        if (instr !== 32'hB000_0008 || p4 !== 32'hC || valid !== 1'b1 || addr !== 32'hC) begin
            n_fail++; $display("FAIL stall_release: got %h/%h/%b addr=%h expected b0000008/c/1 addr=c", instr, p4, valid, addr);
        end
    endtask

    task automatic test_branch();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hC000_000C);
        advance();
        drive(1, 1, 1, 1, 32'h40, 0, 0, 1, 32'hC000_0010);
        advance();
        n_tests++;
        if (valid !== 1'b0 || instr !== NOP || p4 !== 32'h10) begin
            n_fail++; $display("FAIL branch_flush: got %h/%h/%b expected 0/10/0", instr, p4, valid);
        end
        n_tests++; if (addr !== 32'h40) begin n_fail++; $display("FAIL branch_addr: got %h expected 40", addr); end
    endtask

    task automatic test_redirect_wait();
        drive(1, 1, 0, 0, 0, 1, 32'h20, 1, 32'hD000_0040);
        advance();
        drive(1, 1, 0, 0, 0, 1, 32'h100, 0, 32'hEEEE_EEEE);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 32'hEEEE_EEEE);
            #1;
            n_tests++;
            if (addr !== 32'h20 || req !== 1'b1 || stall !== 1'b1 || valid !== 1'b0) begin
                n_fail++; $display("FAIL redir_wait%0d: got addr=%h req=%b stall=%b valid=%b expected 20/1/1/0", i, addr, req, stall, valid);
            end
            advance();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hD000_0020);
        advance();
        n_tests++;
        if (addr !== 32'h100 || valid !== 1'b0 || instr !== NOP) begin
            n_fail++; $display("FAIL redir_done: got addr=%h valid=%b instr=%h expected 100/0/0", addr, valid, instr);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 1, 32'h300, 1, 32'h200, 1, 32'hF000_0100);
        advance();
        n_tests++; if (addr !== 32'h200) begin n_fail++; $display("FAIL prio_jump: got %h expected 200", addr); end
        drive(0, 1, 0, 1, 32'h300, 1, 32'h400, 0, 32'hF000_0000);
        advance();
        n_tests++;
        if (addr !== 32'h200 || req !== 1'b1) begin
            n_fail++; $display("FAIL prio_pcwrite0: got addr=%h req=%b expected 200/1", addr, req);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hF000_0200);
        advance();
        n_tests++;
        if (addr !== 32'h204 || instr !== 32'hF000_0200 || p4 !== 32'h204) begin
            n_fail++; $display("FAIL prio_resume: got addr=%h instr=%h p4=%h expected 204/f0000200/204", addr, instr, p4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 99) < 15), ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 9) == 0), ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 9) < 7), $urandom);
            #1;
            n_tests++;
            if (req !== (m_started && !m_hold) || addr !== m_pc || stall !== (m_started && !m_hold && !rdy)) begin
                n_fail++;
                $display("FAIL rand_fetch%0d: got req=%b addr=%h stall=%b expected req=%b addr=%h stall=%b",
                         i, req, addr, stall, m_started && !m_hold, m_pc, m_started && !m_hold && !rdy);
            end
            advance();
            n_tests++;
            if (instr !== m_instr || p4 !== m_p4 || valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_ifid%0d: got %h/%h/%b expected %h/%h/%b", i, instr, p4, valid, m_instr, m_p4, m_valid);
            end
        end
    endtask

    task automatic test_wrap();
        w_rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_start: got req=%b addr=%h expected 1/fffffffc", w_req, w_addr);
        end
        @(negedge clk);
        n_tests++;
        if (w_p4 !== 32'h0 || w_valid !== 1'b1 || w_instr !== W_RDATA || w_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap: got p4=%h valid=%b instr=%h addr=%h expected 0/1/12345678/0", w_p4, w_valid, w_instr, w_addr);
        end
    endtask

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_stall();
        test_branch();
        test_redirect_wait();
        test_priority();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
